// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, fault reasons and word geometry.
package mem_pkg;

  localparam int MEM_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } mem_state_e;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_MISALIGNED,
    FLT_RANGE,
    FLT_INSTR_WRITE
  } mem_fault_e;

endpackage

// File: rtl/mem_word_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read port.
module mem_word_ram import mem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic                           we,
  input  logic [MEM_WORD_BYTES-1:0]      be,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic [31:0] word_d;

  always_comb begin
    rdata_d = mem_q[addr];
    word_d  = mem_q[addr];
    for (int i = 0; i < MEM_WORD_BYTES; i++) begin
      if (be[i]) word_d[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) mem_q[addr] <= word_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Native memory-port responder: programmable-latency RAM access with fault
// reporting for misaligned, out-of-range and write-fetch requests.
//
//   state   | meaning
//   IDLE    | waiting for mem_valid; request latched on acceptance
//   WAIT    | latency counter running down
//   RESP    | one-cycle mem_ready (+mem_err); write commits at the edge leaving it
module mem_responder import mem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * MEM_WORD_BYTES);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  mem_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;

  logic [31:0] sel_addr;
  logic [31:0] off;
  mem_fault_e  fault_reason;
  logic        ram_we;
  logic [31:0] ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // In IDLE the RAM is addressed straight from the port so a LATENCY=1 read
  // has its data registered by the acceptance edge; otherwise the latched copy.
  assign sel_addr = (state_q == ST_IDLE) ? mem_addr : addr_q;
  assign off      = sel_addr - BASE_ADDR;

  always_comb begin
    fault_reason = FLT_NONE;
    if (addr_q[1:0] != 2'b00)                fault_reason = FLT_MISALIGNED;
    else if (off >= SPAN)                    fault_reason = FLT_RANGE;
    else if (instr_q && (wstrb_q != 4'b0))   fault_reason = FLT_INSTR_WRITE;
  end

  assign mem_ready = (state_q == ST_RESP);
  assign mem_err   = mem_ready && (fault_reason != FLT_NONE);
  assign ram_we    = mem_ready && (fault_reason == FLT_NONE) && (wstrb_q != 4'b0);
  assign mem_rdata = (mem_ready && (fault_reason == FLT_NONE)) ? ram_rdata : 32'h0;

  mem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .addr  (off[AW+1:2]),
    .we    (ram_we),
    .be    (wstrb_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances covering latency 1, 4 and 3
// (the last with a non-zero base and a small RAM).
module tb_mem_responder;

  localparam logic [31:0] BASE2 = 32'h8000_0000;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    logic        chk_rd;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        valid [3];
  logic        instr [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready [3];
  logic        err   [3];
  logic [31:0] rdata [3];

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1)) u_dut0 (
    .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_ready(ready[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]), .mem_err(err[0]));

  mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(4)) u_dut1 (
    .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_ready(ready[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]), .mem_err(err[1]));

  mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE2), .LATENCY(3)) u_dut2 (
    .clk(clk), .reset(reset), .mem_valid(valid[2]), .mem_instr(instr[2]),
    .mem_ready(ready[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
    .mem_wstrb(wstrb[2]), .mem_rdata(rdata[2]), .mem_err(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for mem_ready (bounded), pop and compare the expectation.
  task automatic txn(input int d, input string tag, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] sb, input logic ins,
                     input logic chk_rd, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat);
    exp_t e;
    int   cyc;
    exp_q.push_back('{exp_err, exp_rd, chk_rd, exp_lat});
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = sb; instr[d] = ins;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ready[d] && cyc < 40);
    e = exp_q.pop_front();
    if (!ready[d]) begin
      check({tag, " timeout"}, 32'(ready[d]), 32'd1);
    end else begin
      check({tag, " latency"}, 32'(cyc), 32'(e.lat));
      check({tag, " err"}, 32'(err[d]), 32'(e.err));
      if (e.chk_rd) check({tag, " rdata"}, rdata[d], e.rd);
    end
    valid[d] = 1'b0; wstrb[d] = 4'h0; instr[d] = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   cyc, last, got;
    logic seen;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; instr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset ready", 32'(ready[i]), 32'd0);
      check("reset err", 32'(err[i]), 32'd0);
      check("reset rdata", rdata[i], 32'h0);
    end
    reset = 1'b0;

    // Latency 1: basic read/write, lane strobes, faults.
    txn(0, "w0",        32'h0,  32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1);
    txn(0, "r0",        32'h0,  32'h0,         4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);
    @(negedge clk);
    check("post-resp ready", 32'(ready[0]), 32'd0);
    check("post-resp rdata", rdata[0], 32'h0);
    txn(0, "w10 full",  32'h10, 32'hAAAA_AAAA, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1);
    txn(0, "w10 lanes", 32'h10, 32'h1122_3344, 4'b0101, 1'b0, 1'b1, 32'hAAAA_AAAA, 1'b0, 1);
    txn(0, "r10",       32'h10, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA22_AA44, 1'b0, 1);
    txn(0, "w14 hi",    32'h14, 32'h5566_7788, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 1);
    txn(0, "w14 b3",    32'h14, 32'h9900_0000, 4'b1000, 1'b0, 1'b1, 32'h5566_7788, 1'b0, 1);
    txn(0, "r14",       32'h14, 32'h0,         4'h0, 1'b0, 1'b1, 32'h9966_7788, 1'b0, 1);
    txn(0, "r misalgn", 32'h2,  32'h0,         4'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1);
    txn(0, "w range",   32'h1000, 32'h0,       4'hF, 1'b0, 1'b1, 32'h0, 1'b1, 1);
    txn(0, "r0 after range", 32'h0, 32'h0,     4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);
    txn(0, "fetch wr",  32'h10, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0, 1'b1, 1);
    txn(0, "w misalgn", 32'h11, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0, 1'b1, 1);
    txn(0, "r10 after", 32'h10, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA22_AA44, 1'b0, 1);
    txn(0, "fetch rd",  32'h0,  32'h0,         4'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1);

    // Latency 4: single write then back-to-back reads with mem_valid held.
    txn(1, "l4 w20", 32'h20, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 4);
    for (int k = 0; k < 3; k++) exp_q.push_back('{1'b0, 32'h0BAD_F00D, 1'b1, (k == 0) ? 4 : 5});
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h20; wstrb[1] = 4'h0;
    cyc = 0; last = 0; got = 0;
    while (got < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ready[1]) begin
        e = exp_q.pop_front();
        check("b2b spacing", 32'(cyc - last), 32'(e.lat));
        check("b2b rdata", rdata[1], e.rd);
        check("b2b err", 32'(err[1]), 32'(e.err));
        last = cyc;
        got++;
      end
    end
    valid[1] = 1'b0;
    if (got < 3) begin
      check("b2b timeout", 32'(got), 32'd3);
      exp_q.delete();
    end

    // Latency 3, non-zero base, 16 words: range edges and reset abort.
    txn(2, "l3 w8",     BASE2 + 32'h8,  32'h5555_5555, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 3);
    txn(2, "l3 w3c",    BASE2 + 32'h3C, 32'hCAFE_0001, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0, 3);
    txn(2, "l3 r3c",    BASE2 + 32'h3C, 32'h0,         4'h0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 3);
    txn(2, "l3 below",  BASE2 - 32'h4,  32'h0,         4'h0, 1'b0, 1'b1, 32'h0, 1'b1, 3);
    txn(2, "l3 above",  BASE2 + 32'h40, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0, 1'b1, 3);

    @(negedge clk);
    valid[2] = 1'b1; addr[2] = BASE2 + 32'h8; wdata[2] = 32'h0; wstrb[2] = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort ready", 32'(ready[2]), 32'd0);
    check("abort rdata", rdata[2], 32'h0);
    valid[2] = 1'b0; wstrb[2] = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready[2]) seen = 1'b1;
    end
    check("abort no ready", 32'(seen), 32'd0);
    txn(2, "l3 r8 kept", BASE2 + 32'h8, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
